dpbram_copy_ctrl: RTL and testbench
===================================

# dpbram_copy_ctrl

Sequencing controller for the true dual-port BRAM. It copies a block of words from one region of the memory to another, or fills a region with a constant, at one word per cycle. Port 0 is the read port and port 1 is the write port. It sits between the host/control FSM (start/done handshake) and the BRAM's two ports, and it owns both ports while busy.

## Interface
- DWIDTH, 32, data word width (matches BRAM)
- AWIDTH, 12, address width (matches BRAM)
- MEM_SIZE, 3840, number of valid BRAM words; addresses >= MEM_SIZE are illegal
- clk  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- mode_i  in  1  0 = copy, 1 = fill; latched with start
- src_addr_i  in  AWIDTH  copy source base; ignored in fill mode
- dst_addr_i  in  AWIDTH  destination base
- len_i  in  AWIDTH+1  word count, 0..MEM_SIZE
- fill_data_i  in  DWIDTH  fill constant; latched with start
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  high together with done_o when the request was rejected
- addr0_o  out  AWIDTH, ce0_o  out  1, we0_o  out  1 (constant 0), d0_o  out  DWIDTH (constant 0)  BRAM port 0
- q0_i  in  DWIDTH  BRAM port 0 read data; valid the cycle after ce0_o=1
- addr1_o  out  AWIDTH, ce1_o  out  1, we1_o  out  1, d1_o  out  DWIDTH  BRAM port 1

## Operation
- FSM states: IDLE, CHECK, RUN, DRAIN, DONE.
- IDLE:
  - On start_i=1, latch mode, src, dst, len and fill data, then go to CHECK.
  - start_i in any other state is ignored and is not queued.
- CHECK: one cycle. Reject (go to DONE with err=1, no memory access) if any of the following holds. Comparisons use AWIDTH+2-bit unsigned arithmetic, with no wrap.
  - src+len > MEM_SIZE (copy mode only)
  - dst+len > MEM_SIZE
  - copy mode and src < dst < src+len (forward-overlap hazard)
- In CHECK, len=0 goes to DONE with err=0 and no access. Otherwise go to RUN with k=0.
- RUN, copy mode:
  - Cycle k drives ce0_o=1 and addr0_o=src+k.
  - Cycle k+1 drives ce1_o=1, we1_o=1, addr1_o=dst+k and d1_o=q0_i (combinational pass-through of the BRAM output register).
  - After k=len-1, go to DRAIN for the final write, then DONE.
- dst <= src with overlap is legal: the write to dst+k-1 never collides with the read of src+k.
- RUN, fill mode:
  - Cycle k drives ce1_o=1, we1_o=1, addr1_o=dst+k and d1_o=fill data. Port 0 stays idle.
  - After k=len-1, go straight to DONE.
- DONE: done_o=1 for one cycle, err_o is valid, then unconditionally go to IDLE.
- ce0_o, ce1_o and we1_o are 0 in IDLE, CHECK and DONE, and are never asserted outside their scheduled cycles. addr/d outputs are 0 when the matching ce is low.

## Timing
- Reset values: state IDLE, busy_o=0, done_o=0, err_o=0, ce0_o=ce1_o=we1_o=0, all addr/d outputs 0.
- Cycle numbering: cycle 0 is the cycle in which start_i=1 is seen in IDLE.
  - Copy of N>0 words: cycle 1 CHECK, cycles 2..N+1 reads, cycles 3..N+2 writes (N+2 is DRAIN), done_o in cycle N+3.
  - Fill of N>0 words: writes in cycles 2..N+1, done_o in cycle N+2.
  - Reject or len=0: done_o in cycle 2.
- busy_o rises in cycle 1 and falls in the cycle after done_o. The earliest next start is accepted in that cycle.
- Throughput: one word per cycle, no bubbles.
- Reset mid-operation: the next edge returns to IDLE with all ce low and no done pulse. Words already written stay written.

## Test plan
- Preload mem[10..13]={A,B,C,D}; copy src=10, dst=100, len=4 -> mem[100..103]={A,B,C,D}, done_o in cycle 7, err_o=0, exactly 4 reads and 4 writes.
- Fill dst=3835, len=5, data=0xDEADBEEF -> mem[3835..3839]=0xDEADBEEF, done_o in cycle 7. Repeat with len=6 -> err_o=1 in cycle 2, no writes.
- Copy src=20, dst=22, len=4 -> err_o=1, no access. Copy src=22, dst=20, len=4 with mem[22..25]={1,2,3,4} -> mem[20..23]={1,2,3,4}, err_o=0.
- len=0, copy mode -> done_o in cycle 2, err_o=0, ce0_o/ce1_o never high.
- Start copy with len=8 and assert reset_i in cycle 5 -> next cycle is IDLE, busy_o=0, no done_o, only the words for k<3 written.
- Pulse start_i again during RUN with different parameters -> ignored; the first transfer completes unchanged and a single done_o is seen.

Source files
------------

// File: rtl/dpbram_copy_ctrl.sv
// +--------------------------------------------------------------------+
// | dpbram_copy_ctrl : one-word-per-cycle copy/fill sequencer for BRAM |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dpbram_copy_ctrl #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 12,
   parameter int MEM_SIZE = 3840
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [AWIDTH-1:0] src_addr_i,
   input  logic [AWIDTH-1:0] dst_addr_i,
   input  logic [AWIDTH:0]   len_i,
   input  logic [DWIDTH-1:0] fill_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [AWIDTH-1:0] addr0_o,
   output logic              ce0_o,
   output logic              we0_o,
   output logic [DWIDTH-1:0] d0_o,
   input  logic [DWIDTH-1:0] q0_i,
   output logic [AWIDTH-1:0] addr1_o,
   output logic              ce1_o,
   output logic              we1_o,
   output logic [DWIDTH-1:0] d1_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [AWIDTH+1:0] MEM_LIM  = (AWIDTH+2)'(MEM_SIZE);
   localparam logic [AWIDTH:0]   LEN_ONE  = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);

   state_t              state_q;
   logic                mode_q;
   logic [AWIDTH-1:0]   src_q, dst_q;
   logic [AWIDTH:0]     len_q, k_q;
   logic [DWIDTH-1:0]   fill_q;
   logic                busy_q, done_q, err_q;
   logic                ce0_q, ce1_q, we1_q;
   logic [AWIDTH-1:0]   addr0_q, addr1_q;

   logic [AWIDTH+1:0]   src_x, dst_x, src_end, dst_end;
   logic                reject, last;
   logic [AWIDTH-1:0]   k_a, k_n;

   // Range checks are done two bits wider than the address so nothing wraps.
   assign src_x   = {2'b00, src_q};
   assign dst_x   = {2'b00, dst_q};
   assign src_end = src_x + {1'b0, len_q};
   assign dst_end = dst_x + {1'b0, len_q};
   assign reject  = (!mode_q && (src_end > MEM_LIM))
                  || (dst_end > MEM_LIM)
                  || (!mode_q && (src_x < dst_x) && (dst_x < src_end));

   assign last = (k_q == (len_q - LEN_ONE));
   assign k_a  = k_q[AWIDTH-1:0];
   assign k_n  = k_a + ADDR_ONE;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         k_q     <= '0;
         fill_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ce0_q   <= 1'b0;
         ce1_q   <= 1'b0;
         we1_q   <= 1'b0;
         addr0_q <= '0;
         addr1_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (start_i) begin
                  mode_q  <= mode_i;
                  src_q   <= src_addr_i;
                  dst_q   <= dst_addr_i;
                  len_q   <= len_i;
                  fill_q  <= fill_data_i;
                  busy_q  <= 1'b1;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (reject || (len_q == '0)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= reject;
               end else begin
                  state_q <= S_RUN;
                  k_q     <= '0;
                  if (mode_q) begin
                     ce1_q   <= 1'b1;
                     we1_q   <= 1'b1;
                     addr1_q <= dst_q;
                  end else begin
                     ce0_q   <= 1'b1;
                     addr0_q <= src_q;
                  end
               end
            end
            S_RUN: begin
               k_q <= k_q + LEN_ONE;
               if (mode_q) begin
                  if (last) begin
                     ce1_q   <= 1'b0;
                     we1_q   <= 1'b0;
                     addr1_q <= '0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     addr1_q <= dst_q + k_n;
                  end
               end else begin
                  // Write of word k trails its read by one cycle.
                  ce1_q   <= 1'b1;
                  we1_q   <= 1'b1;
                  addr1_q <= dst_q + k_a;
                  if (last) begin
                     ce0_q   <= 1'b0;
                     addr0_q <= '0;
                     state_q <= S_DRAIN;
                  end else begin
                     addr0_q <= src_q + k_n;
                  end
               end
            end
            S_DRAIN: begin
               ce1_q   <= 1'b0;
               we1_q   <= 1'b0;
               addr1_q <= '0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign addr0_o = addr0_q;
   assign ce0_o   = ce0_q;
   assign we0_o   = 1'b0;
   assign d0_o    = '0;
   assign addr1_o = addr1_q;
   assign ce1_o   = ce1_q;
   assign we1_o   = we1_q;
   assign d1_o    = ce1_q ? (mode_q ? fill_q : q0_i) : '0;

endmodule

`default_nettype wire

// File: tb/tb_dpbram_copy_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_dpbram_copy_ctrl : randomized bench with BRAM and memory model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dpbram_copy_ctrl;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int MS = 3840;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          start_i = 1'b0;
   logic          mode_i = 1'b0;
   logic [AW-1:0] src_addr_i = '0;
   logic [AW-1:0] dst_addr_i = '0;
   logic [AW:0]   len_i = '0;
   logic [DW-1:0] fill_data_i = '0;
   logic          busy_o, done_o, err_o;
   logic [AW-1:0] addr0_o, addr1_o;
   logic          ce0_o, we0_o, ce1_o, we1_o;
   logic [DW-1:0] d0_o, d1_o;
   logic [DW-1:0] q0_i = '0;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:MS-1];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [DW-1:0] poke_data = '0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dpbram_copy_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
      .clk(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .fill_data_i(fill_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .addr0_o(addr0_o), .ce0_o(ce0_o), .we0_o(we0_o), .d0_o(d0_o), .q0_i(q0_i),
      .addr1_o(addr1_o), .ce1_o(ce1_o), .we1_o(we1_o), .d1_o(d1_o)
   );

   // BRAM: registered read on port 0, write on port 1, plus a bench-only preload path.
   always @(posedge clk) begin
      if (ce0_o) q0_i <= mem[addr0_o];
      if (ce1_o && we1_o) mem[addr1_o] <= d1_o;
      if (poke_en) mem[poke_addr] <= poke_data;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic poke(input int addr, input logic [DW-1:0] data);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = AW'(addr);
      poke_data = data;
      ref_mem[addr] = data;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      chk({tag, "_ce0"},  64'(ce0_o),  64'd0);
      chk({tag, "_ce1"},  64'(ce1_o),  64'd0);
      chk({tag, "_we1"},  64'(we1_o),  64'd0);
   endtask

   task automatic chk_mem();
      int bad = 0;
      for (int i = 0; i < MS; i++)
         if (mem[i] !== ref_mem[i]) bad++;
      chk("mem", 64'(bad), 64'd0);
   endtask

   // One request; expectations come from the timing rules (cycle 0 = start seen in IDLE).
   task automatic run_op(input bit mode, input int src, input int dst, input int len,
                         input logic [DW-1:0] fill, input int rst_at, input bit restart);
      bit            rej, ok, e_ce0, e_ce1;
      int            d, last_c, k1, nw;
      logic [DW-1:0] e_d1;
      logic [DW-1:0] sv [$];
      rej = (!mode && (src + len > MS)) || (dst + len > MS)
            || (!mode && (src < dst) && (dst < src + len));
      ok  = !rej && (len > 0);
      d   = !ok ? 2 : (mode ? len + 2 : len + 3);
      if (ok && !mode)
         for (int i = 0; i < len; i++) sv.push_back(ref_mem[src + i]);

      start_i     = 1'b1;
      mode_i      = mode;
      src_addr_i  = AW'(src);
      dst_addr_i  = AW'(dst);
      len_i       = (AW+1)'(len);
      fill_data_i = fill;
      last_c = (rst_at > 0) ? rst_at : d + 1;

      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 1) start_i = 1'b0;
         if (restart && c == 3) begin
            start_i     = 1'b1;
            mode_i      = ~mode;
            src_addr_i  = AW'(src + 7);
            dst_addr_i  = AW'(dst + 50);
            len_i       = (AW+1)'(3);
            fill_data_i = ~fill;
         end
         if (restart && c == 4) start_i = 1'b0;

         e_ce0 = ok && !mode && (c >= 2) && (c <= len + 1);
         e_ce1 = ok && (mode ? ((c >= 2) && (c <= len + 1)) : ((c >= 3) && (c <= len + 2)));
         k1    = mode ? c - 2 : c - 3;
         e_d1  = '0;
         if (e_ce1) e_d1 = mode ? fill : sv[k1];

         chk("busy",  64'(busy_o),  64'(c <= d));
         chk("done",  64'(done_o),  64'(c == d));
         chk("err",   64'(err_o),   64'((c == d) && rej));
         chk("ce0",   64'(ce0_o),   64'(e_ce0));
         chk("addr0", 64'(addr0_o), e_ce0 ? 64'(src + c - 2) : 64'd0);
         chk("ce1",   64'(ce1_o),   64'(e_ce1));
         chk("we1",   64'(we1_o),   64'(e_ce1));
         chk("addr1", 64'(addr1_o), e_ce1 ? 64'(dst + k1) : 64'd0);
         chk("d1",    64'(d1_o),    64'(e_d1));
      end

      if (rst_at > 0) begin
         reset_i = 1'b1;
         @(negedge clk);
         reset_i = 1'b0;
         chk_idle("rst");
         repeat (3) begin
            @(negedge clk);
            chk_idle("post_rst");
         end
         nw = mode ? rst_at - 1 : rst_at - 2;
         if (ok)
            for (int i = 0; i < len && i < nw; i++)
               ref_mem[dst + i] = mode ? fill : sv[i];
      end else if (ok) begin
         for (int i = 0; i < len; i++)
            ref_mem[dst + i] = mode ? fill : sv[i];
      end

      if (restart)
         repeat (4) begin
            @(negedge clk);
            chk_idle("restart");
         end
      chk_mem();
   endtask

   initial begin
      bit            rm;
      int            rs, rd, rl, sel;
      for (int i = 0; i < MS; i++) poke(i, $urandom);
      chk_idle("reset");
      chk("reset_err", 64'(err_o), 64'd0);
      chk("reset_a0",  64'(addr0_o), 64'd0);
      chk("reset_a1",  64'(addr1_o), 64'd0);
      chk("reset_d1",  64'(d1_o), 64'd0);
      @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      chk_idle("idle");
      chk("we0", 64'(we0_o), 64'd0);
      chk("d0",  64'(d0_o),  64'd0);

      run_op(1'b0, 10, 100, 4, '0, 0, 1'b0);
      run_op(1'b1, 0, 3835, 5, 32'hDEADBEEF, 0, 1'b0);
      run_op(1'b1, 0, 3835, 6, 32'hDEADBEEF, 0, 1'b0);
      run_op(1'b0, 20, 22, 4, '0, 0, 1'b0);
      for (int i = 0; i < 4; i++) poke(22 + i, DW'(i + 1));
      run_op(1'b0, 22, 20, 4, '0, 0, 1'b0);
      run_op(1'b0, 5, 50, 0, '0, 0, 1'b0);
      run_op(1'b0, 200, 300, 8, '0, 5, 1'b0);
      run_op(1'b0, 400, 500, 10, '0, 0, 1'b1);
      run_op(1'b0, 3830, 0, 10, '0, 0, 1'b0);
      run_op(1'b0, 3831, 0, 10, '0, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         rm  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         rl  = (sel == 0) ? 0 : $urandom_range(1, 24);
         rs  = ($urandom_range(0, 3) == 0) ? MS - $urandom_range(0, 30) : $urandom_range(0, MS - 1);
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            rd = rs + $urandom_range(0, 20) - 10;
            if (rd < 0) rd = 0;
         end else if (sel == 1) begin
            rd = MS - $urandom_range(0, 30);
         end else begin
            rd = $urandom_range(0, MS - 1);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(rm, rs, rd, rl, $urandom, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
